// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, opcodes,
// ALU ops, mux selects and the bundled control word.
package mc_ctrl_pkg;

   localparam logic [3:0] ST_FETCH  = 4'd0;
   localparam logic [3:0] ST_DECODE = 4'd1;
   localparam logic [3:0] ST_MEMADR = 4'd2;
   localparam logic [3:0] ST_MEMRD  = 4'd3;
   localparam logic [3:0] ST_MEMWB  = 4'd4;
   localparam logic [3:0] ST_MEMWR  = 4'd5;
   localparam logic [3:0] ST_EXEC   = 4'd6;
   localparam logic [3:0] ST_RWB    = 4'd7;
   localparam logic [3:0] ST_ADDIEX = 4'd8;
   localparam logic [3:0] ST_ADDIWB = 4'd9;
   localparam logic [3:0] ST_BRANCH = 4'd10;
   localparam logic [3:0] ST_JUMP   = 4'd11;

   localparam logic [2:0] OP_RTYPE = 3'd0;
   localparam logic [2:0] OP_ADDI  = 3'd1;
   localparam logic [2:0] OP_LW    = 3'd2;
   localparam logic [2:0] OP_SW    = 3'd3;
   localparam logic [2:0] OP_BEQ   = 3'd4;
   localparam logic [2:0] OP_J     = 3'd5;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_SLT = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_AND = 3'd4;

   localparam logic [1:0] SRCB_REGB = 2'd0;
   localparam logic [1:0] SRCB_ONE  = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_sel;
      logic       instr_done;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// R-type function decoder: maps funct to an ALU op and flags codes with no ALU op.
module alu_ctrl_dec
   import mc_ctrl_pkg::*;
(
   input  logic [3:0] funct,
   output logic [2:0] alu_sel,
   output logic       illegal
);

   always_comb begin
      illegal = (funct > 4'd4);
      alu_sel = illegal ? ALU_ADD : funct[2:0];
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 16-bit MIPS-subset datapath.
// Define MULTICYCLE_CTRL_JUMP_EN to decode opcode 5 as a jump.
module multicycle_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic [3:0] funct,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       ir_write,
   output logic       reg_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [2:0] alu_sel,
   output logic       instr_done,
   output logic       illegal,
   output logic [3:0] state
);

   logic [3:0] state_reg;
   logic [3:0] state_next;
   logic [2:0] funct_alu_sel;
   logic       funct_illegal;
   logic       op_illegal;
   ctrl_t      ctrl;

   alu_ctrl_dec u_alu_ctrl_dec (
      .funct   (funct),
      .alu_sel (funct_alu_sel),
      .illegal (funct_illegal)
   );

   always_comb begin
      case (opcode)
         OP_RTYPE:                      op_illegal = funct_illegal;
         OP_ADDI, OP_LW, OP_SW, OP_BEQ: op_illegal = 1'b0;
`ifdef MULTICYCLE_CTRL_JUMP_EN
         OP_J:                          op_illegal = 1'b0;
`endif
         default:                       op_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_FETCH:  if (mem_ready) state_next = ST_DECODE;
         ST_DECODE: begin
            state_next = ST_FETCH;
            if (!op_illegal) begin
               case (opcode)
                  OP_RTYPE:     state_next = ST_EXEC;
                  OP_ADDI:      state_next = ST_ADDIEX;
                  OP_LW, OP_SW: state_next = ST_MEMADR;
                  OP_BEQ:       state_next = ST_BRANCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
                  OP_J:         state_next = ST_JUMP;
`endif
                  default:      state_next = ST_FETCH;
               endcase
            end
         end
         ST_MEMADR: state_next = (opcode == OP_LW) ? ST_MEMRD :
                                 (opcode == OP_SW) ? ST_MEMWR : ST_FETCH;
         ST_MEMRD:  if (mem_ready) state_next = ST_MEMWB;
         ST_MEMWR:  if (mem_ready) state_next = ST_FETCH;
         ST_EXEC:   state_next = ST_RWB;
         ST_ADDIEX: state_next = ST_ADDIWB;
         default:   state_next = ST_FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) state_reg <= ST_FETCH;
      else        state_reg <= state_next;
   end

   // Everything is forced low while reset is held, even before the state register reloads.
   always_comb begin
      ctrl = '0;
      if (reset) begin
         case (state_reg)
            ST_FETCH: begin
               ctrl.mem_read  = 1'b1;
               ctrl.alu_src_b = SRCB_ONE;
               ctrl.ir_write  = mem_ready;
               ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
               ctrl.alu_src_b = SRCB_IMM;
               ctrl.illegal   = op_illegal;
            end
            ST_MEMADR, ST_ADDIEX: begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
               ctrl.mem_read = 1'b1;
               ctrl.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
               ctrl.reg_write  = 1'b1;
               ctrl.mem_to_reg = 1'b1;
               ctrl.instr_done = 1'b1;
            end
            ST_MEMWR: begin
               ctrl.mem_write  = 1'b1;
               ctrl.i_or_d     = 1'b1;
               ctrl.instr_done = mem_ready;
            end
            ST_EXEC: begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRCB_REGB;
               ctrl.alu_sel   = funct_alu_sel;
            end
            ST_RWB: begin
               ctrl.reg_write  = 1'b1;
               ctrl.reg_dst    = 1'b1;
               ctrl.instr_done = 1'b1;
            end
            ST_ADDIWB: begin
               ctrl.reg_write  = 1'b1;
               ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
               ctrl.alu_src_a     = 1'b1;
               ctrl.alu_src_b     = SRCB_REGB;
               ctrl.alu_sel       = ALU_SUB;
               ctrl.pc_write_cond = 1'b1;
               ctrl.pc_source     = PCSRC_ALUOUT;
               ctrl.instr_done    = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_JUMP_EN
            ST_JUMP: begin
               ctrl.pc_write   = 1'b1;
               ctrl.pc_source  = PCSRC_JUMP;
               ctrl.instr_done = 1'b1;
            end
`endif
            default: ctrl = '0;
         endcase
      end
   end

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign ir_write      = ctrl.ir_write;
   assign reg_write     = ctrl.reg_write;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign i_or_d        = ctrl.i_or_d;
   assign reg_dst       = ctrl.reg_dst;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign pc_source     = ctrl.pc_source;
   assign alu_sel       = ctrl.alu_sel;
   assign instr_done    = ctrl.instr_done;
   assign illegal       = ctrl.illegal;
   assign state         = reset ? state_reg : ST_FETCH;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the 16-bit MIPS-subset datapath. It sequences the shared ALU, the 2:1 and 4:1 operand multiplexers, the sign extender path, the instruction register, the PC and the register file across FETCH/DECODE/EXECUTE/MEM/WRITEBACK cycles. It handshakes with a single unified memory port. It sits between the instruction register opcode/funct fields and every datapath enable and select.

## Interface
- Parameters: none; widths are fixed by the 16-bit ISA.
- clock  in  1  rising-edge system clock
- reset  in  1  synchronous, active-low reset
- opcode  in  3  instruction bits [15:13], taken from the instruction register
- funct  in  4  instruction bits [3:0], R-type function
- mem_ready  in  1  memory completed the current read/write this cycle
- pc_write, pc_write_cond, ir_write, reg_write  out  1  datapath write enables
- mem_read, mem_write  out  1  memory request strobes
- i_or_d  out  1  memory address mux: 0 PC, 1 ALUOut
- reg_dst  out  1  write register: 0 rt, 1 rd
- mem_to_reg  out  1  write data: 0 ALUOut, 1 MDR
- alu_src_a  out  1  MUX2 select: 0 PC, 1 regA
- alu_src_b  out  2  MUX4 select: 0 regB, 1 constant 1, 2 sign-extended imm7, 3 unused
- pc_source  out  2  0 ALU result, 1 ALUOut, 2 jump target
- alu_sel  out  3  ALU op: 0 add, 1 sub, 2 slt, 3 or, 4 and
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse on an undecodable instruction
- state  out  4  current state, for debug

## Operation
- Opcodes: 0 R-type, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 J (macro-gated), 6–7 illegal. R-type funct 0–4 maps directly to alu_sel. funct ≥5 is illegal.
- Outputs are Moore-decoded from state, except ir_write/pc_write in FETCH, which are gated by mem_ready. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, add. If mem_ready, assert ir_write=1 and pc_write=1 and go to DECODE. Otherwise hold.
- DECODE: alu_src_a=0, alu_src_b=2, add (branch target into ALUOut). Next state: R→EXEC, ADDI→ADDIEX, LW/SW→MEMADR, BEQ→BRANCH, J→JUMP. Illegal opcode or funct→illegal=1, next FETCH.
- MEMADR: alu_src_a=1, alu_src_b=2, add. LW→MEMRD, SW→MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Then FETCH.
- MEMWR: mem_write=1, i_or_d=1. Hold until mem_ready; on mem_ready assert instr_done=1 and go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=0, alu_sel=funct[2:0]. Then RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=2, add. Then ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, instr_done=1. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, sub, pc_write_cond=1, pc_source=1, instr_done=1. Then FETCH.
- JUMP: pc_write=1, pc_source=2, instr_done=1. Then FETCH.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.

## Timing
- Reset: while reset=0, all outputs are 0. The state register loads FETCH at the edge. The first fetch request appears in the cycle after reset deasserts.
- Reset asserted mid-instruction or mid-memory-wait overrides everything, with no write enables that cycle.
- Cycles with zero wait states: BEQ/J 3, R/ADDI/SW 4, LW 5. Each memory wait cycle adds 1.
- mem_read and mem_write stay asserted, with a stable i_or_d, until the cycle in which mem_ready=1.

## Configuration
- MULTICYCLE_CTRL_JUMP_EN defined: opcode 5 decodes to JUMP.
- Not defined: JUMP state is absent, opcode 5 is illegal (illegal pulse, return to FETCH), and pc_source never drives 2.

## Structure
- Package mc_ctrl_pkg holds:
  - state encodings (4-bit)
  - opcode constants
  - ALU op constants
  - alu_src_b and pc_source select constants
- One sub-module, alu_ctrl_dec: funct→alu_sel plus funct-illegal flag, used in DECODE and EXEC.

## Test plan
- Reset held 3 cycles, then released with mem_ready=1 → all outputs 0 during reset; state FETCH; mem_read=1 the next cycle.
- R-type funct=1 (sub), mem_ready=1 → states FETCH,DECODE,EXEC,RWB; alu_sel=1 in EXEC; reg_write=1 and reg_dst=1 in RWB; instr_done pulses once.
- LW with mem_ready low for 2 cycles in MEMRD → mem_read and i_or_d=1 held for 3 cycles; total 7 cycles; MEMWB has mem_to_reg=1.
- BEQ → 3 cycles; BRANCH drives alu_sel=1, pc_write_cond=1, pc_source=1.
- Opcode 7, and R-type funct=6 → illegal pulses in DECODE; no write enables; returns to FETCH.
- Opcode 5 with and without MULTICYCLE_CTRL_JUMP_EN → JUMP with pc_source=2 when defined, illegal pulse when not. Reset dropped during MEMWR wait → mem_write=0 immediately; FETCH after release.
